// File: rtl/phase_a_pkg.sv
// phase_a_pkg: controller states, default operand widths and width helpers.
package phase_a_pkg;
    typedef enum logic [2:0] {IDLE, LOAD, ISSUE, WAIT, DONE} state_t;
    localparam int SIZE_DEF = 3072;
    localparam int RADIX_DEF = 72;
    localparam int SIZE_LOG_DEF = 6;
    localparam int W_DEF = SIZE_DEF + RADIX_DEF + SIZE_LOG_DEF;
    function automatic int w_of(input int size, input int radix, input int size_log);
        return size + radix + size_log;
    endfunction
    function automatic int mn_w(input int size);
        return size + 2;
    endfunction
    function automatic int mp_w(input int radix, input int size_log);
        return radix + size_log + 2;
    endfunction
    function automatic int iw_of(input int n_iter);
        return $clog2(n_iter + 1);
    endfunction
endpackage

// File: rtl/wide_add_w.sv
// wide_add_w: registered W-bit sum of the partial product and the zero-extended accumulator.
module wide_add_w
    import phase_a_pkg::*;
#(
    parameter int W = W_DEF,
    parameter int AW = SIZE_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic [W-1:0]  a,
    input  logic [AW-1:0] b,
    output logic [W-1:0]  sum
);
    always_ff @(posedge clk) begin
        if (rst) sum <= '0;
        else if (en) sum <= a + W'(b);
    end
endmodule

// File: rtl/phase_a_ctrl.sv
// phase_a_ctrl: issues N_ITER en/en_out rounds to phase_a and returns the reduced result.
module phase_a_ctrl
    import phase_a_pkg::*;
#(
    parameter int Size = SIZE_DEF,
    parameter int radix = RADIX_DEF,
    parameter int Size_log = SIZE_LOG_DEF,
    parameter int N_ITER = 43,
    parameter int TIMEOUT = 32,
    localparam int W = w_of(Size, radix, Size_log),
    localparam int MNW = mn_w(Size),
    localparam int MPW = mp_w(radix, Size_log)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [Size-1:0] m,
    input  logic [MNW-1:0]  m_n,
    input  logic [MPW-1:0]  m_prime,
    output logic            busy,
    input  logic [W-1:0]    p_data,
    input  logic            p_valid,
    output logic            p_ready,
    output logic [W-1:0]    pa_a,
    output logic [Size-1:0] pa_m,
    output logic [MNW-1:0]  pa_m_n,
    output logic [MPW-1:0]  pa_m_prime,
    output logic            pa_en,
    output logic            pa_if_last,
    input  logic [Size-1:0] pa_new_a,
    input  logic            pa_en_out,
    output logic [Size-1:0] res_data,
    output logic            res_valid,
    input  logic            res_ready,
    output logic            err
);
    localparam int IW = iw_of(N_ITER);
    localparam int TW = $clog2(TIMEOUT + 1);

    state_t state, state_n;
    logic [Size-1:0] acc;
    logic [IW-1:0] iter;
    logic [TW-1:0] wd;
    logic load_fire, round_done, expired;

    assign busy = state != IDLE;
    assign p_ready = state == LOAD;
    assign pa_en = state == ISSUE;
    assign res_valid = state == DONE;
    assign res_data = acc;

    // wd counts cycles since pa_en; a returning en_out beats expiry in the same cycle
    always_comb begin
        load_fire = state == LOAD && p_valid;
        round_done = state == WAIT && pa_en_out;
        expired = state == WAIT && !pa_en_out && wd == TW'(TIMEOUT - 1);
        state_n = state;
        case (state)
            IDLE:    state_n = start ? LOAD : IDLE;
            LOAD:    state_n = p_valid ? ISSUE : LOAD;
            ISSUE:   state_n = WAIT;
            WAIT:    state_n = pa_en_out ? (pa_if_last ? DONE : LOAD) : (expired ? IDLE : WAIT);
            DONE:    state_n = res_ready ? IDLE : DONE;
            default: state_n = IDLE;
        endcase
    end

    wide_add_w #(.W(W), .AW(Size)) u_add (
        .clk(clk),
        .rst(rst),
        .en(load_fire),
        .a(p_data),
        .b(acc),
        .sum(pa_a)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            acc <= '0;
            iter <= '0;
            wd <= '0;
            err <= 1'b0;
            pa_m <= '0;
            pa_m_n <= '0;
            pa_m_prime <= '0;
            pa_if_last <= 1'b0;
        end else begin
            state <= state_n;
            if (state == IDLE && start) begin
                acc <= '0;
                iter <= '0;
                err <= 1'b0;
                pa_m <= m;
                pa_m_n <= m_n;
                pa_m_prime <= m_prime;
            end
            if (load_fire) pa_if_last <= iter == IW'(N_ITER - 1);
            if (state == ISSUE) wd <= TW'(1);
            else if (state == WAIT) wd <= wd + 1'b1;
            if (round_done) begin
                acc <= pa_new_a;
                iter <= iter + 1'b1;
            end
            if (expired) begin
                err <= 1'b1;
                acc <= '0;
            end
            if (pa_en_out && state != WAIT) err <= 1'b1;
        end
    end
endmodule
